// File: rtl/pq_sevenseg_display.sv
// pq_sevenseg_display
//   Latches one key/value byte pair per load strobe and time-multiplexes it
//   as four hex digits onto a common-anode 7-segment display.
//   Digits 3..2 show the key and digits 1..0 show the value. The decimal
//   point on digit 2 separates the key from the value.
//
// Parameters
//   DIGIT_PERIOD  clock cycles each digit stays enabled (>= 2)
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   load    in   1  strobe: capture key_in/val_in and start showing them
//   clear   in   1  strobe: blank the display; wins over load
//   key_in  in   8  key byte
//   val_in  in   8  value byte
//   an      out  4  digit enables, active-low
//   seg     out  7  segments gfedcba, active-low
//   dp      out  1  decimal point, active-low
//   shown   out  1  high while a latched pair is on display
//
// Optional feature macro: PQ_DISP_LZB_EN
//   When defined, the high nibble of each byte is blanked if it is zero.
//   The blanked digit keeps its anode slot but lights no segments.

module pq_sevenseg_display #(
  parameter int DIGIT_PERIOD = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] key_in,
  input  logic [7:0] val_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       shown
);

  localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_PERIOD - 1);

  localparam logic [3:0] AN_DARK  = 4'b1111;
  localparam logic [6:0] SEG_DARK = 7'h7F;

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;
  logic [7:0]       key_r;
  logic [7:0]       val_r;
  logic             shown_r;

  logic [3:0]       nib;
  logic             blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  logic [3:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---- stage p0: refresh counter, digit index, latched pair ----
  // The scan free-runs from reset; load/clear never restart it, so a new
  // pair simply appears in whatever slot is currently active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= 2'd0;
    end else if (cnt_p0 == CNT_MAX) begin
      cnt_p0 <= '0;
      idx_p0 <= idx_p0 + 2'd1;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // clear has priority: a coincident load is dropped entirely, and the
  // previously latched bytes are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r   <= 8'h00;
      val_r   <= 8'h00;
      shown_r <= 1'b0;
    end else if (clear) begin
      shown_r <= 1'b0;
    end else if (load) begin
      key_r   <= key_in;
      val_r   <= val_in;
      shown_r <= 1'b1;
    end
  end

  always_comb begin
    nib     = 4'h0;
    blank   = 1'b0;
    an_nxt  = AN_DARK;
    seg_nxt = SEG_DARK;
    dp_nxt  = 1'b1;

    case (idx_p0)
      2'd0:    nib = val_r[3:0];
      2'd1:    nib = val_r[7:4];
      2'd2:    nib = key_r[3:0];
      default: nib = key_r[7:4];
    endcase

`ifdef PQ_DISP_LZB_EN
    // Only the high nibble of each byte may blank, so 8'h00 still reads "0".
    blank = ((idx_p0 == 2'd3) && (key_r[7:4] == 4'h0)) ||
            ((idx_p0 == 2'd1) && (val_r[7:4] == 4'h0));
`else
    blank = 1'b0;
`endif

    if (shown_r) begin
      an_nxt  = ~(4'b0001 << idx_p0);
      seg_nxt = blank ? SEG_DARK : hex7(nib);
      dp_nxt  = (idx_p0 != 2'd2);
    end
  end

  // ---- stage p1: registered pin drivers ----
  // Reset forces the pins dark directly, so an async reset never passes
  // through an all-segments-on state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_p1  <= AN_DARK;
      seg_p1 <= SEG_DARK;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
      dp_p1  <= dp_nxt;
    end
  end

  assign an    = an_p1;
  assign seg   = seg_p1;
  assign dp    = dp_p1;
  assign shown = shown_r;

endmodule

// File: tb/tb_pq_sevenseg_display.sv
module tb_pq_sevenseg_display;

  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic [7:0] val_in = 8'h00;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       shown;

  pq_sevenseg_display #(.DIGIT_PERIOD(DP)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .clear  (clear),
    .key_in (key_in),
    .val_in (val_in),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .shown  (shown)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset release; cycle k is sampled on the negedge after posedge k.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       shown;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef PQ_DISP_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "idle_dark";
      2: return "load_latency";
      3: return "scan_3a5c";
      4: return "clear_tail";
      5: return "load_clear_dark";
      6: return "scan_ff01";
      7: return "scan_1201";
      8: return "async_reset";
      9: return "scan_0700";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input logic sh, input int t);
    exp_t e;
    e.c = c; e.an = a; e.seg = s; e.dp = d; e.shown = sh; e.tag = t;
    q.push_back(e);
  endtask

  task automatic push_dark(input int k0, input int k1, input logic sh, input int t);
    for (int k = k0; k <= k1; k++) push(k, 4'b1111, 7'h7F, 1'b1, sh, t);
  endtask

  // s0..s3: hand-decoded segment patterns for digit slots 0..3.
  task automatic push_scan(input int k0, input int k1,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int t);
    int i;
    for (int k = k0; k <= k1; k++) begin
      i = ((k - 1) / DP) % 4;
      case (i)
        0: push(k, 4'b1110, s0, 1'b1, 1'b1, t);
        1: push(k, 4'b1101, s1, 1'b1, 1'b1, t);
        2: push(k, 4'b1011, s2, 1'b0, 1'b1, t);
        default: push(k, 4'b0111, s3, 1'b1, 1'b1, t);
      endcase
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s: cycle %0d never sampled (now at %0d)", tag_name(e.tag), e.c, cyc);
      end else if (an !== e.an || seg !== e.seg || dp !== e.dp || shown !== e.shown) begin
        errors++;
        $display("FAIL %s @%0d: got an=%b seg=%h dp=%b shown=%b, want an=%b seg=%h dp=%b shown=%b",
                 tag_name(e.tag), cyc, an, seg, dp, shown, e.an, e.seg, e.dp, e.shown);
      end
    end
  end

  initial begin
    push(0, 4'b1111, 7'h7F, 1'b1, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    push_dark(1, 40, 1'b0, 1);
    wait_cyc(40);

    load = 1'b1; key_in = 8'h3A; val_in = 8'h5C;
    push(41, 4'b1111, 7'h7F, 1'b1, 1'b1, 2);
    push_scan(42, 61, 7'h46, 7'h12, 7'h08, 7'h30, 3);
    wait_cyc(41);
    load = 1'b0;

    wait_cyc(61);
    clear = 1'b1;
    push(62, 4'b0111, 7'h30, 1'b1, 1'b0, 4);
    push_dark(63, 70, 1'b0, 5);
    wait_cyc(62);
    clear = 1'b0;

    wait_cyc(65);
    load = 1'b1; clear = 1'b1; key_in = 8'hAA; val_in = 8'hAA;
    wait_cyc(66);
    load = 1'b0; clear = 1'b0;

    wait_cyc(70);
    load = 1'b1; key_in = 8'hFF; val_in = 8'h01;
    push(71, 4'b1111, 7'h7F, 1'b1, 1'b1, 2);
    push_scan(72, 89, 7'h79, LZ, 7'h0E, 7'h0E, 6);
    wait_cyc(71);
    load = 1'b0;

    // Digit 2 is active over cycles 88..91; reload the key in the middle of it.
    wait_cyc(88);
    load = 1'b1; key_in = 8'h12;
    push_scan(90, 106, 7'h79, LZ, 7'h24, 7'h79, 7);
    push(107, 4'b1111, 7'h7F, 1'b1, 1'b0, 8);
    wait_cyc(89);
    load = 1'b0;

    wait_cyc(107);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    load = 1'b1; key_in = 8'h07; val_in = 8'h00;
    push(1, 4'b1111, 7'h7F, 1'b1, 1'b1, 2);
    push_scan(2, 17, 7'h40, LZ, 7'h78, LZ, 9);
    wait_cyc(1);
    load = 1'b0;

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
